// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 8x8 LED matrix scan controller.
package led_matrix_pkg;

    localparam int unsigned N_ROWS = 8;
    localparam int unsigned N_COLS = 8;

    typedef logic [2:0]        row_idx_t;
    typedef logic [N_COLS-1:0] col_pattern_t;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    // One-hot row drive for the given row index.
    function automatic logic [N_ROWS-1:0] row_onehot(input row_idx_t idx);
        row_onehot = N_ROWS'(1) << idx;
    endfunction

endpackage

// File: rtl/led_matrix_frame_buffer.sv
// Double-buffered 8x8 frame store: writes land in the back bank, the scan reads the display bank.
module led_matrix_frame_buffer
    import led_matrix_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  row_idx_t     wr_row,
    input  col_pattern_t wr_data,
    input  logic         swap,
    input  row_idx_t     rd_row,
    output col_pattern_t rd_data_c
);

    col_pattern_t bank [2][N_ROWS];
    logic         disp_sel;
    logic         back_sel;

    assign back_sel = ~disp_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_sel <= 1'b0;
            bank[0]  <= '{default: '0};
            bank[1]  <= '{default: '0};
        end else begin
            if (wr_en) begin
                bank[back_sel][wr_row] <= wr_data;
            end
            if (swap) begin
                disp_sel <= ~disp_sel;
            end
        end
    end

    assign rd_data_c = bank[disp_sel][rd_row];

endmodule

// File: rtl/led_matrix_scan_controller.sv
// Row-multiplexed scan sequencer for the 8x8 LED matrix with blanking between rows.
// Optional PWM brightness control is enabled with `define LED_MATRIX_PWM_EN.
module led_matrix_scan_controller
    import led_matrix_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 12500,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic       frame_start,
    output logic [7:0] rows,
    output logic [7:0] cols
`ifdef LED_MATRIX_PWM_EN
    ,
    input  logic [3:0] brightness
`endif
);

    localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam row_idx_t         LAST_ROW   = 3'(N_ROWS - 1);

    if (DWELL_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_bad_params
        $error("led_matrix_scan_controller: DWELL_CYCLES and BLANK_CYCLES must be >= 1");
    end

    scan_state_t      state;
    row_idx_t         row_idx;
    logic [CNT_W-1:0] cnt;
    col_pattern_t     rd_data_c;
    logic             blank_done_c;
    logic             dwell_done_c;
    logic             frame_end_c;
    logic             wr_en_c;
    logic             swap_now_c;
    logic             pending_next_c;

    assign blank_done_c = (state == BLANK) && (cnt == BLANK_LAST);
    assign dwell_done_c = (state == DRIVE) && (cnt == DWELL_LAST);
    assign frame_end_c  = dwell_done_c && (row_idx == LAST_ROW);
    assign wr_en_c      = wr_valid && wr_ready;

    // A pending swap lands at the frame boundary, or straight away while idle.
    assign swap_now_c     = swap_pending && ((state == IDLE) || frame_end_c);
    assign pending_next_c = swap_now_c ? 1'b0 : (swap_pending | swap_req);

    led_matrix_frame_buffer u_frame_buffer (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en_c),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .swap      (swap_now_c),
        .rd_row    (row_idx),
        .rd_data_c (rd_data_c)
    );

`ifdef LED_MATRIX_PWM_EN
    col_pattern_t pat_q;
    logic [31:0]  thr_q;
    logic [31:0]  thr_new_c;

    assign thr_new_c = ((32'(brightness) + 32'd1) * DWELL_CYCLES) >> 4;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            row_idx      <= '0;
            cnt          <= '0;
            rows         <= '0;
            cols         <= '0;
            frame_start  <= 1'b0;
            swap_pending <= 1'b0;
            wr_ready     <= 1'b1;
`ifdef LED_MATRIX_PWM_EN
            pat_q        <= '0;
            thr_q        <= '0;
`endif
        end else begin
            frame_start  <= 1'b0;
            swap_pending <= pending_next_c;
            wr_ready     <= ~pending_next_c;

            if (!enable) begin
                state   <= IDLE;
                row_idx <= '0;
                cnt     <= '0;
                rows    <= '0;
                cols    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state       <= BLANK;
                        row_idx     <= '0;
                        cnt         <= '0;
                        frame_start <= 1'b1;
                        rows        <= '0;
                        cols        <= '0;
                    end
                    BLANK: begin
                        if (blank_done_c) begin
                            state <= DRIVE;
                            cnt   <= '0;
                            rows  <= row_onehot(row_idx);
`ifdef LED_MATRIX_PWM_EN
                            pat_q <= rd_data_c;
                            thr_q <= thr_new_c;
                            cols  <= (thr_new_c != 32'd0) ? rd_data_c : '0;
`else
                            cols  <= rd_data_c;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DRIVE: begin
                        if (dwell_done_c) begin
                            state       <= BLANK;
                            cnt         <= '0;
                            row_idx     <= row_idx + 3'(1);
                            rows        <= '0;
                            cols        <= '0;
                            frame_start <= frame_end_c;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
`ifdef LED_MATRIX_PWM_EN
                            // Column drive for the next dwell cycle follows the sampled duty.
                            cols <= ((32'(cnt) + 32'd1) < thr_q) ? pat_q : '0;
`endif
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_controller.sv
// Bench for led_matrix_scan_controller: directed and random stimulus against a frame-timeline model.
module tb_led_matrix_scan_controller;

`ifdef LED_MATRIX_PWM_EN
    localparam int DWELL = 16;
`else
    localparam int DWELL = 4;
`endif
    localparam int BLANK      = 2;
    localparam int ROW_PERIOD = DWELL + BLANK;
    localparam int FRAME      = 8 * ROW_PERIOD;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_pending;
    logic       frame_start;
    logic [7:0] rows;
    logic [7:0] cols;
`ifdef LED_MATRIX_PWM_EN
    logic [3:0] brightness;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: two frames, display index, pending flag, position in the frame timeline.
    logic [7:0] m_frame [2][8];
    logic       m_disp;
    logic       m_pending;
    logic       m_running;
    int         m_t;

    always #5 clk = ~clk;

    led_matrix_scan_controller #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .frame_start  (frame_start),
        .rows         (rows),
        .cols         (cols)
`ifdef LED_MATRIX_PWM_EN
        ,
        .brightness   (brightness)
`endif
    );

    function automatic void model_step();
        if (reset) begin
            foreach (m_frame[b, r]) m_frame[b][r] = '0;
            m_disp    = 1'b0;
            m_pending = 1'b0;
            m_running = 1'b0;
            m_t       = 0;
            return;
        end
        if (wr_valid && !m_pending) m_frame[~m_disp][wr_row] = wr_data;
        if (m_pending && (!m_running || m_t == FRAME - 1)) begin
            m_disp    = ~m_disp;
            m_pending = 1'b0;
        end else if (swap_req) begin
            m_pending = 1'b1;
        end
        if (!enable) begin
            m_running = 1'b0;
        end else if (!m_running) begin
            m_running = 1'b1;
            m_t       = 0;
        end else begin
            m_t = (m_t + 1) % FRAME;
        end
    endfunction

    function automatic void model_expect(output logic [7:0] e_rows, output logic [7:0] e_cols,
                                         output logic e_fs);
        int r;
        int w;
        e_rows = '0;
        e_cols = '0;
        e_fs   = 1'b0;
        if (m_running) begin
            r    = m_t / ROW_PERIOD;
            w    = m_t % ROW_PERIOD;
            e_fs = (m_t == 0);
            if (w >= BLANK) begin
                e_rows = 8'(1) << r;
                e_cols = m_frame[m_disp][r];
`ifdef LED_MATRIX_PWM_EN
                if ((w - BLANK) >= ((int'(brightness) + 1) * DWELL) / 16) e_cols = '0;
`endif
            end
        end
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic [7:0] e_rows;
        logic [7:0] e_cols;
        logic       e_fs;
        @(posedge clk);
        model_step();
        #1;
        model_expect(e_rows, e_cols, e_fs);
        check("rows", rows, e_rows);
        check("cols", cols, e_cols);
        check("frame_start", {7'b0, frame_start}, {7'b0, e_fs});
        check("swap_pending", {7'b0, swap_pending}, {7'b0, m_pending});
        check("wr_ready", {7'b0, wr_ready}, {7'b0, ~m_pending});
    endtask

    task automatic wait_rows(input logic [7:0] target);
        int n = 0;
        while (rows !== target && n < 2 * FRAME) begin
            tick();
            n++;
        end
        check("wait_rows", rows, target);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        wr_valid = 1'b0;
        wr_row   = '0;
        wr_data  = '0;
        swap_req = 1'b0;
`ifdef LED_MATRIX_PWM_EN
        brightness = 4'd15;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic scan: blanking, one-hot rows, frame_start spacing.
        enable = 1'b1;
        repeat (2 * FRAME + 4) tick();

        // Write row 3 then request a swap while scanning.
        wr_valid = 1'b1; wr_row = 3'd3; wr_data = 8'hA5;
        tick();
        wr_valid = 1'b0;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (2 * FRAME) tick();

        // Write and swap in the same cycle, then a redundant swap request.
        wr_valid = 1'b1; wr_row = 3'd5; wr_data = 8'h3C; swap_req = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        swap_req = 1'b0;
        repeat (2 * FRAME) tick();

        // Drop enable during row 4 drive, then re-enable.
        wait_rows(8'h10);
        tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (FRAME + ROW_PERIOD) tick();

        // Reset mid-drive with a swap pending, then show both banks are clear.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        wait_rows(8'h04);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (FRAME + 2) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (2 * FRAME) tick();

`ifdef LED_MATRIX_PWM_EN
        // Duty check: load a full pattern, compare low and full brightness.
        enable = 1'b0;
        for (int r = 0; r < 8; r++) begin
            wr_valid = 1'b1; wr_row = 3'(r); wr_data = 8'hFF;
            tick();
        end
        wr_valid = 1'b0;
        swap_req = 1'b1;
        brightness = 4'd3;
        tick();
        swap_req = 1'b0;
        tick();
        enable = 1'b1;
        repeat (FRAME) tick();
        enable = 1'b0;
        brightness = 4'd15;
        tick();
        enable = 1'b1;
        repeat (FRAME) tick();
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 499) == 0);
            enable   = ($urandom_range(0, 149) != 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_row   = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            swap_req = ($urandom_range(0, 19) == 0);
`ifdef LED_MATRIX_PWM_EN
            if (!enable) brightness = 4'($urandom_range(0, 15));
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
